// File: rtl/if_fetch_queue_pkg.sv
// Shared types and helpers for the instruction-fetch prefetch queue.
package if_fetch_queue_pkg;

    localparam int unsigned XLEN = 32;

    // One buffered instruction together with the address it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] ir;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } if_fetch_state_t;

    // Sequential instruction address; wraps modulo 2^32.
    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched entries; flush wins over push/pop.
module fetch_fifo
    import if_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type         T     = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  T                       i_data,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_valid,
    output T                       o_head
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    T              r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[PW'(i)] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_valid = (r_count != '0);
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch unit: owns the fetch PC, keeps one icache request in
// flight and buffers returned instructions for ID in a prefetch queue.
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h4000_0060
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    input  logic        imem_resp,
    input  logic [31:0] imem_rdata,
    output logic        imem_read,
    output logic [31:0] imem_address,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_next,
    output logic [31:0] if_ir
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    if_fetch_state_t r_state;
    logic [31:0]     r_fetch_pc;
    logic [31:0]     r_req_addr;
    logic            r_imem_read;

    logic [31:0]     w_target;
    logic [1:0]      w_unused_pc_lsb;
    logic            w_pop;
    logic            w_push;
    logic            w_valid;
    logic [CW-1:0]   w_count;
    logic [CW-1:0]   w_count_after_pop;
    logic [CW-1:0]   w_count_after_push;
    fetch_entry_t    w_push_entry;
    fetch_entry_t    w_head;

    // Redirect targets are word aligned; the low bits are deliberately dropped.
    assign w_target        = {redirect_pc[31:2], 2'b00};
    assign w_unused_pc_lsb = redirect_pc[1:0];

    // A redirect suppresses both the ID handoff and any same-cycle response.
    assign w_pop              = w_valid & id_ready & ~redirect;
    assign w_push             = (r_state == REQ) & imem_resp & ~redirect;
    assign w_count_after_pop  = w_count - CW'(w_pop);
    assign w_count_after_push = w_count_after_pop + CW'(w_push);
    assign w_push_entry       = '{pc: r_req_addr, ir: imem_rdata};

    fetch_fifo #(
        .DEPTH (DEPTH),
        .T     (fetch_entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .i_flush (redirect),
        .o_count (w_count),
        .o_valid (w_valid),
        .o_head  (w_head)
    );

    // Fetch FSM: request sequencing, redirect handling and stale-response drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= REQ;
            r_fetch_pc  <= RESET_PC;
            r_req_addr  <= RESET_PC;
            r_imem_read <= 1'b1;
        end else if (redirect) begin
            r_fetch_pc  <= w_target;
            r_imem_read <= 1'b1;
            case (r_state)
                IDLE: begin
                    r_state    <= REQ;
                    r_req_addr <= w_target;
                end
                REQ: begin
                    if (imem_resp) begin
                        r_req_addr <= w_target;
                    end else begin
                        r_state <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (imem_resp) begin
                        r_state    <= REQ;
                        r_req_addr <= w_target;
                    end
                end
                default: begin
                    r_state    <= REQ;
                    r_req_addr <= w_target;
                end
            endcase
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_count_after_pop < CW'(DEPTH)) begin
                        r_state     <= REQ;
                        r_req_addr  <= r_fetch_pc;
                        r_imem_read <= 1'b1;
                    end
                end
                REQ: begin
                    if (imem_resp) begin
                        r_fetch_pc <= pc_plus4(r_req_addr);
                        if (w_count_after_push < CW'(DEPTH)) begin
                            r_req_addr <= pc_plus4(r_req_addr);
                        end else begin
                            r_state     <= IDLE;
                            r_imem_read <= 1'b0;
                        end
                    end
                end
                DISCARD: begin
                    if (imem_resp) begin
                        r_state    <= REQ;
                        r_req_addr <= r_fetch_pc;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_imem_read <= 1'b0;
                end
            endcase
        end
    end

    assign imem_read    = r_imem_read;
    assign imem_address = r_req_addr;
    assign if_valid     = w_valid;
    assign if_pc        = w_head.pc;
    assign if_pc_next   = pc_plus4(w_head.pc);
    assign if_ir        = w_head.ir;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for the instruction-fetch prefetch queue.
module tb_if_fetch_queue;

    localparam logic [31:0] RPC = 32'h4000_0060;

    logic        clk;
    logic        rst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        imem_resp;
    logic [31:0] imem_rdata;
    logic        imem_read;
    logic [31:0] imem_address;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_pc_next;
    logic [31:0] if_ir;

    int checks;
    int failures;

    if_fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (RPC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .id_ready     (id_ready),
        .imem_resp    (imem_resp),
        .imem_rdata   (imem_rdata),
        .imem_read    (imem_read),
        .imem_address (imem_address),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_pc_next   (if_pc_next),
        .if_ir        (if_ir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        id_ready    = 1'b0;
        imem_resp   = 1'b0;
        imem_rdata  = 32'h0;
        tick();
        tick();

        // Reset values
        chk("rst_valid",   32'(if_valid),  32'd0);
        chk("rst_pc",      if_pc,          32'h0);
        chk("rst_pc_next", if_pc_next,     32'h4);
        chk("rst_ir",      if_ir,          32'h0);
        chk("rst_read",    32'(imem_read), 32'd1);
        chk("rst_addr",    imem_address,   RPC);

        // Streaming: hit every cycle, ID always ready
        rst       = 1'b0;
        id_ready  = 1'b1;
        imem_resp = 1'b1;
        for (int k = 0; k < 6; k++) begin
            imem_rdata = (RPC + 32'(4 * k)) ^ 32'h0000_FFFF;
            tick();
            chk("str_valid",   32'(if_valid), 32'd1);
            chk("str_pc",      if_pc,         RPC + 32'(4 * k));
            chk("str_pc_next", if_pc_next,    RPC + 32'(4 * k + 4));
            chk("str_ir",      if_ir,         (RPC + 32'(4 * k)) ^ 32'h0000_FFFF);
            chk("str_addr",    imem_address,  RPC + 32'(4 * k + 4));
        end

        // Reset mid-REQ with an entry queued
        imem_resp = 1'b0;
        id_ready  = 1'b0;
        rst       = 1'b1;
        tick();
        chk("mrst_valid", 32'(if_valid),  32'd0);
        chk("mrst_addr",  imem_address,   RPC);
        chk("mrst_read",  32'(imem_read), 32'd1);

        // Fill to DEPTH with ID stalled
        rst       = 1'b0;
        imem_resp = 1'b1;
        for (int k = 0; k < 4; k++) begin
            imem_rdata = (RPC + 32'(4 * k)) ^ 32'h0000_FFFF;
            tick();
            chk("fill_read", 32'(imem_read), (k == 3) ? 32'd0 : 32'd1);
        end
        imem_resp = 1'b0;
        tick();
        tick();
        chk("full_read",  32'(imem_read), 32'd0);
        chk("full_valid", 32'(if_valid),  32'd1);
        chk("full_pc",    if_pc,          RPC);

        // Release ID: one pop, fetch resumes at 0x4000_0070
        id_ready = 1'b1;
        tick();
        chk("resume_pc",   if_pc,          RPC + 32'h4);
        chk("resume_read", 32'(imem_read), 32'd1);
        chk("resume_addr", imem_address,   32'h4000_0070);

        // Push and pop together with three queued: order preserved
        imem_resp  = 1'b1;
        imem_rdata = 32'h4000_0070 ^ 32'h0000_FFFF;
        tick();
        chk("pp_pc",   if_pc,        RPC + 32'h8);
        chk("pp_addr", imem_address, 32'h4000_0074);
        imem_resp = 1'b0;
        tick();
        chk("drain0_pc", if_pc, RPC + 32'hC);
        tick();
        chk("drain1_pc", if_pc, 32'h4000_0070);
        chk("drain1_ir", if_ir, 32'h4000_0070 ^ 32'h0000_FFFF);
        tick();
        chk("drain_empty", 32'(if_valid), 32'd0);

        // Redirect with a pending request and no response: DISCARD
        id_ready    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h4000_1003;
        tick();
        redirect = 1'b0;
        chk("disc_valid", 32'(if_valid),  32'd0);
        chk("disc_read",  32'(imem_read), 32'd1);
        chk("disc_addr",  imem_address,   32'h4000_0074);
        tick();
        chk("disc_hold",  imem_address,   32'h4000_0074);
        imem_resp  = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        chk("disc_drop_valid", 32'(if_valid), 32'd0);
        chk("disc_new_addr",   imem_address,  32'h4000_1000);
        imem_rdata = 32'h4000_1000 ^ 32'h0000_FFFF;
        tick();
        chk("tgt_valid", 32'(if_valid), 32'd1);
        chk("tgt_pc",    if_pc,         32'h4000_1000);
        chk("tgt_ir",    if_ir,         32'h4000_EFFF);
        chk("tgt_addr",  imem_address,  32'h4000_1004);

        // Redirect on the same cycle as a response: response dropped
        redirect    = 1'b1;
        redirect_pc = 32'h4000_2000;
        imem_rdata  = 32'h1234_5678;
        tick();
        redirect = 1'b0;
        chk("same_valid", 32'(if_valid),  32'd0);
        chk("same_addr",  imem_address,   32'h4000_2000);
        chk("same_read",  32'(imem_read), 32'd1);
        imem_resp = 1'b0;
        tick();
        chk("same_empty", 32'(if_valid), 32'd0);
        imem_resp  = 1'b1;
        imem_rdata = 32'h4000_2000 ^ 32'h0000_FFFF;
        tick();
        imem_resp = 1'b0;
        chk("same2_valid",   32'(if_valid), 32'd1);
        chk("same2_pc",      if_pc,         32'h4000_2000);
        chk("same2_pc_next", if_pc_next,    32'h4000_2004);
        chk("same2_ir",      if_ir,         32'h4000_DFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
